mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15, the bus cycles waited for bus_ready before an access is aborted.
REQ-002 SHALL provide parameter FAIR_LIMIT, default 4, the consecutive MEM grants allowed while IF is pending (used only with ARB_FAIRNESS_EN).
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports if_req in 1 and if_addr in 32, the instruction-fetch request and address.
REQ-006 SHALL have ports if_rdata out 32 and if_ack out 1, the fetched word and a one-cycle completion pulse.
REQ-007 SHALL have ports mem_rd in 1, mem_wr in 1, mem_addr in 32 and mem_wdata in 32, the MEM-stage load/store request.
REQ-008 SHALL have ports mem_rdata out 32 and mem_ack out 1, the load data and a one-cycle completion pulse.
REQ-009 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32 and bus_wdata out 32, driving the single memory port.
REQ-010 SHALL have ports bus_rdata in 32 and bus_ready in 1, the memory return data and completion strobe.
REQ-011 SHALL have ports stall_if out 1, stall_mem out 1 and bus_err out 1, the pipeline stall lines and a timeout flag.

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY_IF, BUSY_MEM and RESP.
REQ-013 SHALL arbitrate only in IDLE: MEM pending (mem_rd|mem_wr) goes to BUSY_MEM, else if_req goes to BUSY_IF, else stay in IDLE.
REQ-014 SHALL latch address, write data and direction on the IDLE->BUSY edge, with bus_req, bus_we, bus_addr and bus_wdata registered and stable throughout BUSY.
REQ-015 SHALL treat mem_rd and mem_wr both high as a write.
REQ-016 SHALL, in BUSY, go to RESP on the edge where bus_ready=1, capturing bus_rdata and deasserting bus_req on that edge.
REQ-017 SHALL, in RESP, assert exactly one of if_ack/mem_ack for one cycle with the captured data on if_rdata/mem_rdata, then go to IDLE.
REQ-018 SHALL give a minimum access latency of 3 cycles from request seen in IDLE to ack, i.e. IDLE, BUSY (bus_ready=1), RESP.
REQ-019 SHALL hold mem_rdata and if_rdata at their last values outside RESP, and SHALL NOT change mem_rdata on a write completion.
REQ-020 SHALL count BUSY cycles; when the count reaches TIMEOUT with no bus_ready, SHALL go to RESP with bus_err=1 for that RESP cycle, returned data 32'h0, and bus_req dropped.
REQ-021 SHALL ignore bus_ready outside BUSY.
REQ-022 SHALL drive stall_if = if_req & ~if_ack and stall_mem = (mem_rd|mem_wr) & ~mem_ack, both combinational.
REQ-023 SHALL require requesters to hold request and operands stable until their ack; new requests are sampled in the IDLE cycle following RESP.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE and clear the timeout and fairness counters.
REQ-025 SHALL reset bus_req, bus_we, if_ack, mem_ack and bus_err to 0, and bus_addr, bus_wdata, if_rdata and mem_rdata to 32'h0.
REQ-026 SHALL, on a reset during BUSY, abandon the access with no ack and bus_req low from the next cycle.

Configuration
REQ-027 SHALL, with ARB_FAIRNESS_EN defined, count consecutive MEM grants made while if_req=1, and grant IF at the next IDLE with both pending once the count equals FAIR_LIMIT.
REQ-028 SHALL, with ARB_FAIRNESS_EN defined, clear the fairness count on any IF grant, and on any IDLE cycle with if_req=0.
REQ-029 SHALL, without ARB_FAIRNESS_EN, use strict MEM priority with no fairness counter synthesized.

Verification
REQ-030 SHALL cover: if_req=1, addr 0x40, bus_ready one cycle after bus_req, bus_rdata 0x8C220004 -> if_ack pulse in cycle 3 with if_rdata=0x8C220004 and stall_if low after it.
REQ-031 SHALL cover: if_req and mem_wr (addr 0x100, data 0xDEADBEEF) together -> MEM first with bus_we=1, bus_wdata=0xDEADBEEF, then IF granted after RESP and IDLE.
REQ-032 SHALL cover: bus_ready held low for 15 cycles on a mem_rd -> mem_ack and bus_err pulse together, mem_rdata=0, bus_req low.
REQ-033 SHALL cover: rst asserted in cycle 2 of BUSY_MEM -> no ack, bus_req=0 next cycle, and a clean access afterwards.
REQ-034 SHALL cover: with ARB_FAIRNESS_EN, mem_rd held continuously and if_req=1 -> 4 MEM grants then one IF grant; without the macro -> only MEM grants.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF/MEM) arbiter for a single memory port with bus timeout.
// Optional IF anti-starvation is enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT    = 15,
  parameter int FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          bus_req_reg, bus_req_next;
  logic          bus_we_reg, bus_we_next;
  logic [31:0]   bus_addr_reg, bus_addr_next;
  logic [31:0]   bus_wdata_reg, bus_wdata_next;
  logic [31:0]   if_rdata_reg, if_rdata_next;
  logic [31:0]   mem_rdata_reg, mem_rdata_next;
  logic          if_ack_reg, if_ack_next;
  logic          mem_ack_reg, mem_ack_next;
  logic          bus_err_reg, bus_err_next;

  logic          mem_pend;
  logic          fair_block;
  logic          grant_mem, grant_if;
  logic          done, done_err;
  logic [31:0]   done_data;

  assign mem_pend  = mem_rd | mem_wr;
  assign grant_mem = (state_reg == IDLE) && mem_pend && !fair_block;
  assign grant_if  = (state_reg == IDLE) && if_req && !grant_mem;

`ifdef ARB_FAIRNESS_EN
  localparam int FW = $clog2(FAIR_LIMIT + 1);

  logic [FW-1:0] fair_reg, fair_next;

  // Once MEM has won FAIR_LIMIT times in a row over a waiting IF, IF goes next.
  assign fair_block = if_req && (fair_reg == FW'(FAIR_LIMIT));

  always_comb begin
    fair_next = fair_reg;
    if (state_reg == IDLE) begin
      if (!if_req || grant_if)
        fair_next = '0;
      else if (grant_mem)
        fair_next = fair_reg + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      fair_reg <= '0;
    else
      fair_reg <= fair_next;
  end
`else
  // FAIR_LIMIT is meaningless here; this folds to a constant 0 (strict MEM priority).
  assign fair_block = (FAIR_LIMIT < 0);
`endif

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;
    if_ack_next    = 1'b0;
    mem_ack_next   = 1'b0;
    bus_err_next   = 1'b0;
    done           = 1'b0;
    done_err       = 1'b0;
    done_data      = 32'h0;

    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (grant_mem) begin
          state_next     = BUSY_MEM;
          bus_req_next   = 1'b1;
          bus_we_next    = mem_wr;
          bus_addr_next  = mem_addr;
          bus_wdata_next = mem_wdata;
        end else if (grant_if) begin
          state_next    = BUSY_IF;
          bus_req_next  = 1'b1;
          bus_we_next   = 1'b0;
          bus_addr_next = if_addr;
        end
      end

      BUSY_IF, BUSY_MEM: begin
        // A ready on the last allowed cycle still counts as a normal completion.
        if (bus_ready) begin
          done      = 1'b1;
          done_data = bus_rdata;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          timer_next = timer_reg + TW'(1);
        end

        if (done) begin
          state_next   = RESP;
          bus_req_next = 1'b0;
          bus_err_next = done_err;
          if (state_reg == BUSY_MEM) begin
            mem_ack_next = 1'b1;
            if (!bus_we_reg)
              mem_rdata_next = done_data;
          end else begin
            if_ack_next   = 1'b1;
            if_rdata_next = done_data;
          end
        end
      end

      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= 32'h0;
      bus_wdata_reg <= 32'h0;
      if_rdata_reg  <= 32'h0;
      mem_rdata_reg <= 32'h0;
      if_ack_reg    <= 1'b0;
      mem_ack_reg   <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
      if_ack_reg    <= if_ack_next;
      mem_ack_reg   <= mem_ack_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_rdata = mem_rdata_reg;
  assign if_ack    = if_ack_reg;
  assign mem_ack   = mem_ack_reg;
  assign bus_err   = bus_err_reg;
  assign stall_if  = if_req & ~if_ack_reg;
  assign stall_mem = mem_pend & ~mem_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-by-cycle transaction model.
// Honours ARB_FAIRNESS_EN the same way the design does.
module tb_mem_port_arbiter;

  localparam int TIMEOUT    = 15;
  localparam int FAIR_LIMIT = 4;

  logic        clk, rst;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        mem_rd, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        stall_if, stall_mem, bus_err;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .FAIR_LIMIT(FAIR_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int txn_count = 0;
  int seen_if, seen_mem;

  // Model of the access in flight: owner 0 none, 1 IF, 2 MEM.
  int          m_owner, m_wait, m_lat, m_fair;
  logic        m_resp_valid, m_resp_mem, m_resp_err, m_we;
  logic [31:0] m_addr, m_wdata, m_resp_data, m_if_rdata, m_mem_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_lat = 0; m_fair = 0;
    m_resp_valid = 1'b0; m_resp_mem = 1'b0; m_resp_err = 1'b0; m_we = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_resp_data = 32'h0;
    m_if_rdata = 32'h0; m_mem_rdata = 32'h0;
  endtask

  task automatic complete(input logic [31:0] d, input logic err);
    m_resp_valid = 1'b1;
    m_resp_mem   = (m_owner == 2);
    m_resp_err   = err;
    m_resp_data  = d;
    if (m_owner == 1)
      m_if_rdata = d;
    else if (!m_we)
      m_mem_rdata = d;
    m_owner = 0;
  endtask

  task automatic model_update(input int mode);
    logic mem_pend, pick_if, fair_turn;
    int   r;
    if (rst) begin
      model_reset();
    end else if (m_resp_valid) begin
      m_resp_valid = 1'b0;
    end else if (m_owner != 0) begin
      if (bus_ready)
        complete(bus_rdata, 1'b0);
      else if (m_wait == TIMEOUT - 1)
        complete(32'h0, 1'b1);
      else
        m_wait++;
    end else begin
      mem_pend = mem_rd | mem_wr;
`ifdef ARB_FAIRNESS_EN
      fair_turn = (m_fair == FAIR_LIMIT);
`else
      fair_turn = 1'b0;
`endif
      pick_if = if_req && (!mem_pend || fair_turn);
      if (pick_if) begin
        m_owner = 1; m_we = 1'b0; m_addr = if_addr;
      end else if (mem_pend) begin
        m_owner = 2; m_we = mem_wr; m_addr = mem_addr; m_wdata = mem_wdata;
      end
      m_wait = 0;
      if (mode == 1) begin
        m_lat = 0;
      end else begin
        r = $urandom_range(0, 9);
        if (r < 6)      m_lat = $urandom_range(0, 2);
        else if (r < 9) m_lat = $urandom_range(3, 13);
        else            m_lat = $urandom_range(14, 18);
      end
`ifdef ARB_FAIRNESS_EN
      if (!if_req || pick_if)
        m_fair = 0;
      else if (m_owner == 2)
        m_fair++;
`endif
    end
  endtask

  // mode 0: random traffic, 1: both requesters saturating, 2: held in reset
  task automatic step(input int mode);
    logic exp_if_ack, exp_mem_ack;
    int   r;
    @(negedge clk);
    exp_if_ack  = m_resp_valid && !m_resp_mem;
    exp_mem_ack = m_resp_valid && m_resp_mem;
    check_eq("bus_req", bus_req, m_owner != 0);
    if (m_owner != 0) begin
      check_eq("bus_we", bus_we, m_we);
      check_eq("bus_addr", bus_addr, m_addr);
      if (m_we) check_eq("bus_wdata", bus_wdata, m_wdata);
    end
    check_eq("if_ack", if_ack, exp_if_ack);
    check_eq("mem_ack", mem_ack, exp_mem_ack);
    check_eq("bus_err", bus_err, m_resp_valid && m_resp_err);
    check_eq("if_rdata", if_rdata, m_if_rdata);
    check_eq("mem_rdata", mem_rdata, m_mem_rdata);
    if (if_ack) seen_if++;
    if (mem_ack) seen_mem++;
    if (m_resp_valid) begin
      txn_count++;
      $display("txn %0d: %s %s addr=%08h data=%08h err=%0d", txn_count,
               m_resp_mem ? "MEM" : "IF", m_we ? "wr" : "rd", m_addr,
               (m_resp_mem && m_we) ? m_wdata : m_resp_data, m_resp_err);
    end

    rst = 1'b0;
    case (mode)
      2: begin
        rst = 1'b1; if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      end
      1: begin
        if_req = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
        if (exp_if_ack) if_addr = $urandom;
        if (exp_mem_ack) mem_addr = $urandom;
      end
      default: begin
        if (exp_if_ack || !if_req) begin
          if_req  = ($urandom_range(0, 2) != 0);
          if_addr = $urandom;
        end
        if (exp_mem_ack || !(mem_rd | mem_wr)) begin
          r = $urandom_range(0, 3);
          mem_rd    = (r == 1) || (r == 3);
          mem_wr    = (r == 2) || (r == 3);
          mem_addr  = $urandom;
          mem_wdata = $urandom;
        end
        if (m_owner == 2 && m_wait == 1 && $urandom_range(0, 5) == 0)
          rst = 1'b1;
      end
    endcase
    if (m_owner != 0)
      bus_ready = (m_wait == m_lat);
    else
      bus_ready = ($urandom_range(0, 2) == 0);
    bus_rdata = $urandom;

    #1;
    check_eq("stall_if", stall_if, if_req & ~exp_if_ack);
    check_eq("stall_mem", stall_mem, (mem_rd | mem_wr) & ~exp_mem_ack);
    model_update(mode);
  endtask

  initial begin
    int exp_if_grants, exp_mem_grants;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    bus_ready = 1'b0; bus_rdata = 32'h0;
    model_reset();

    for (int i = 0; i < 3; i++) step(2);

    // Saturated contention: 30 cycles hold exactly 10 three-cycle accesses.
    seen_if = 0; seen_mem = 0;
    for (int i = 0; i < 30; i++) step(1);
`ifdef ARB_FAIRNESS_EN
    exp_if_grants  = 10 / (FAIR_LIMIT + 1);
`else
    exp_if_grants  = 0;
`endif
    exp_mem_grants = 10 - exp_if_grants;
    check_eq("contention_if_grants", seen_if, exp_if_grants);
    check_eq("contention_mem_grants", seen_mem, exp_mem_grants);

    for (int i = 0; i < 4000; i++) step(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
